// File: rtl/universal_counter_monitor.sv
// Shadow-model checker for the N-bit universal binary counter: tracks the expected
// count from the tapped controls and flags every cycle where q or the ticks diverge.
module universal_counter_monitor #(
  parameter int N     = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             halt_on_err,
  input  logic             syn_clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [N-1:0]     d,
  input  logic [N-1:0]     q,
  input  logic             max_tick,
  input  logic             min_tick,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail,
  output logic [N-1:0]     first_q,
  output logic [N-1:0]     first_exp,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_SYNC  = 2'b00;
  localparam logic [1:0] ST_CHECK = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam logic [N-1:0]     Q_ONES   = {N{1'b1}};
  localparam logic [ERR_W-1:0] CNT_ONES = {ERR_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     exp_q, exp_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_q, fail_d;
  logic [N-1:0]     first_q_q, first_q_d;
  logic [N-1:0]     first_exp_q, first_exp_d;

  logic             mismatch;
  logic [N-1:0]     base;
  logic [N-1:0]     exp_step;

  always_comb begin
    mismatch = (state_q == ST_CHECK) &&
               ((q != exp_q) ||
                (max_tick != (q == Q_ONES)) ||
                (min_tick != (q == '0)));

    // After a mismatch the model follows q, so a single fault is reported once.
    base = ((state_q == ST_CHECK) && !mismatch) ? exp_q : q;

    if (syn_clr)         exp_step = '0;
    else if (load)       exp_step = d;
    else if (en && up)   exp_step = base + 1'b1;
    else if (en && !up)  exp_step = base - 1'b1;
    else                 exp_step = base;
  end

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d     = state_q;
    exp_d       = exp_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    fail_d      = fail_q;
    first_q_d   = first_q_q;
    first_exp_d = first_exp_q;

    case (state_q)
      ST_SYNC: begin
        exp_d = exp_step;
        if (chk_en) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        exp_d = exp_step;
        if (!chk_en) begin
          state_d = ST_SYNC;
        end else if (mismatch) begin
          err_d = 1'b1;
          if (err_cnt_q != CNT_ONES) err_cnt_d = err_cnt_q + 1'b1;
          if (!fail_q) begin
            fail_d      = 1'b1;
            first_q_d   = q;
            first_exp_d = exp_q;
          end
          if (halt_on_err) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and clears every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      exp_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      fail_q      <= 1'b0;
      first_q_q   <= '0;
      first_exp_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      fail_q      <= fail_d;
      first_q_q   <= first_q_d;
      first_exp_q <= first_exp_d;
    end
  end

  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign fail      = fail_q;
  assign first_q   = first_q_q;
  assign first_exp = first_exp_q;
  assign state     = state_q;

endmodule
